// File: rtl/alsu_pkg.sv
// Shared definitions for the ALSU front-end: opcodes, command layout, FSM states.
// Field offsets are functions of WIDTH so the layout scales with operand size.
package alsu_pkg;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_XOR     = 3'b001;
    localparam logic [2:0] OP_ADD     = 3'b010;
    localparam logic [2:0] OP_MULT    = 3'b011;
    localparam logic [2:0] OP_SUB_ABS = 3'b100;
    localparam logic [2:0] OP_DIV     = 3'b101;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic int cmd_w(input int w);
        return 2*w + 8;
    endfunction

    function automatic int off_a(input int w);     return 0;       endfunction
    function automatic int off_b(input int w);     return w;       endfunction
    function automatic int off_cin(input int w);   return 2*w;     endfunction
    function automatic int off_red_a(input int w); return 2*w + 1; endfunction
    function automatic int off_red_b(input int w); return 2*w + 2; endfunction
    function automatic int off_op(input int w);    return 2*w + 3; endfunction
    function automatic int off_byp_a(input int w); return 2*w + 6; endfunction
    function automatic int off_byp_b(input int w); return 2*w + 7; endfunction

endpackage

// File: rtl/alsu_req_arbiter_rr_picker.sv
// Round-robin picker: first set bit of valid at or above ptr, wrapping modulo N.
// Purely combinational so it can be dropped in front of any shared resource.
module rr_picker #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [IDXW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IDXW-1:0] grant_idx
);

    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && valid[j]) begin
                found     = 1'b1;
                grant[j]  = 1'b1;
                grant_idx = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/alsu_req_arbiter.sv
// Shares one combinational ALSU between NUM_REQ requesters: round-robin grant,
// registered operands, one settle cycle, then a tagged valid/ready response.
module alsu_req_arbiter
    import alsu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 4,
    localparam int CMD_W   = 2*WIDTH + 8,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         alsu_A,
    output logic [WIDTH-1:0]         alsu_B,
    output logic                     alsu_Cin,
    output logic                     alsu_red_op_A,
    output logic                     alsu_red_op_B,
    output logic                     alsu_bypass_A,
    output logic                     alsu_bypass_B,
    output logic [2:0]               alsu_Opcode,
    input  logic [2*WIDTH-1:0]       alsu_out,
    input  logic                     alsu_odd_parity,
    input  logic                     alsu_invalid,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [2*WIDTH-1:0]       rsp_out,
    output logic                     rsp_odd_parity,
    output logic                     rsp_invalid,
    output logic [7:0]               invalid_count,
    output logic                     busy
);

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       id_q, id_d;
    logic [CMD_W-1:0]     cmd_q, cmd_d;
    logic [2*WIDTH-1:0]   out_q, out_d;
    logic                 par_q, par_d;
    logic                 inv_q, inv_d;
    logic [7:0]           cnt_q, cnt_d;

    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       gidx;
    logic [CMD_W-1:0]     cmd_sel;

    rr_picker #(.N(NUM_REQ), .IDXW(IDW)) u_picker (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign cmd_sel = req_cmd[gidx*CMD_W +: CMD_W];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cmd_d     = cmd_q;
        out_d     = out_q;
        par_d     = par_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant;
                    cmd_d     = cmd_sel;
                    id_d      = gidx;
                    ptr_d     = (gidx == IDW'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                out_d   = alsu_out;
                par_d   = alsu_odd_parity;
                inv_d   = alsu_invalid;
                if (alsu_invalid && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cmd_q   <= '0;
            out_q   <= '0;
            par_q   <= 1'b0;
            inv_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cmd_q   <= cmd_d;
            out_q   <= out_d;
            par_q   <= par_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands stay on the ALSU after capture until the next grant.
    assign alsu_A        = cmd_q[off_a(WIDTH)     +: WIDTH];
    assign alsu_B        = cmd_q[off_b(WIDTH)     +: WIDTH];
    assign alsu_Cin      = cmd_q[off_cin(WIDTH)];
    assign alsu_red_op_A = cmd_q[off_red_a(WIDTH)];
    assign alsu_red_op_B = cmd_q[off_red_b(WIDTH)];
    assign alsu_Opcode   = cmd_q[off_op(WIDTH)    +: 3];
    assign alsu_bypass_A = cmd_q[off_byp_a(WIDTH)];
    assign alsu_bypass_B = cmd_q[off_byp_b(WIDTH)];

    assign rsp_valid      = (state_q == RESP);
    assign rsp_id         = id_q;
    assign rsp_out        = out_q;
    assign rsp_odd_parity = par_q;
    assign rsp_invalid    = inv_q;
    assign invalid_count  = cnt_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_alsu_req_arbiter.sv
// Randomized scoreboard bench for alsu_req_arbiter with a behavioural ALSU attached.
// A transaction-level model predicts grants; a monitor checks every response cycle.
module tb_alsu_req_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 2*W + 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_cmd;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    alsu_A, alsu_B;
    logic            alsu_Cin, alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
    logic [2:0]      alsu_Opcode;
    logic [2*W-1:0]  alsu_out;
    logic            alsu_odd_parity, alsu_invalid;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [2*W-1:0]  rsp_out;
    logic            rsp_odd_parity, rsp_invalid;
    logic [7:0]      invalid_count;
    logic            busy;

    always #5 clk = ~clk;

    alsu_req_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_cmd(req_cmd), .req_ready(req_ready),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_Cin(alsu_Cin),
        .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
        .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
        .alsu_Opcode(alsu_Opcode), .alsu_out(alsu_out),
        .alsu_odd_parity(alsu_odd_parity), .alsu_invalid(alsu_invalid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_odd_parity(rsp_odd_parity), .rsp_invalid(rsp_invalid),
        .invalid_count(invalid_count), .busy(busy)
    );

    // Behavioural ALSU: returns {invalid, odd_parity, out}.
    function automatic logic [9:0] alsu_fn(input logic [15:0] c);
        logic [3:0] a, b;
        logic [2:0] op;
        logic [7:0] o;
        logic       inv;
        a = c[3:0]; b = c[7:4]; op = c[13:11];
        o = 8'd0; inv = 1'b0;
        if (op == 3'b110 || op == 3'b111) inv = 1'b1;
        else if ((c[9] || c[10]) && op != 3'b000 && op != 3'b001) inv = 1'b1;
        else if (c[14]) o = {4'd0, a};
        else if (c[15]) o = {4'd0, b};
        else begin
            case (op)
                3'b000: o = c[9] ? {7'd0, &a} : c[10] ? {7'd0, &b} : {4'd0, a & b};
                3'b001: o = c[9] ? {7'd0, ^a} : c[10] ? {7'd0, ^b} : {4'd0, a ^ b};
                3'b010: o = 8'(a) + 8'(b) + 8'(c[8]);
                3'b011: o = 8'(a) * 8'(b);
                3'b100: o = (a >= b) ? 8'(a - b) : 8'(b - a);
                default: begin
                    if (b == 4'd0) inv = 1'b1;
                    else o = 8'(a / b);
                end
            endcase
        end
        return {inv, ^o, o};
    endfunction

    always_comb {alsu_invalid, alsu_odd_parity, alsu_out} =
        alsu_fn({alsu_bypass_B, alsu_bypass_A, alsu_Opcode, alsu_red_op_B,
                 alsu_red_op_A, alsu_Cin, alsu_B, alsu_A});

    typedef struct {
        int          id;
        logic [7:0]  out;
        logic        par;
        logic        inv;
        logic [7:0]  cnt;
        logic [15:0] cmd;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          responses = 0;
    bit          pend[N];
    logic [15:0] pcmd[N];
    int          mptr, mph, mcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mk_cmd(input logic [2:0] op, input logic [3:0] a,
                                           input logic [3:0] b, input logic cin);
        return {2'b00, op, 2'b00, cin, b, a};
    endfunction

    function automatic logic [15:0] rand_cmd(input int mode);
        logic [15:0] c;
        c        = 16'($urandom);
        c[13:11] = (mode == 1) ? 3'b111 : 3'($urandom_range(0, 7));
        c[9]     = ($urandom_range(0, 7) == 0);
        c[10]    = ($urandom_range(0, 7) == 0);
        c[14]    = ($urandom_range(0, 7) == 0);
        c[15]    = ($urandom_range(0, 7) == 0);
        return c;
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) if (pend[(mptr + k) % N]) return (mptr + k) % N;
        return -1;
    endfunction

    // One clock of stimulus plus the model's view of the coming edge.
    task automatic cycle(input int mode, input bit do_rst, input bit gen,
                         input int rdy_pct, input bit chk_zero);
        int          g;
        logic [9:0]  r;
        exp_t        e;
        logic [N-1:0] er;
        @(negedge clk);
        if (gen)
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(0, 99) < 40) begin
                    pend[i] = 1'b1;
                    pcmd[i] = rand_cmd(mode);
                end
        rsp_ready = ($urandom_range(0, 99) < rdy_pct);
        rst_n     = !do_rst;
        for (int i = 0; i < N; i++) begin
            req_valid[i]        = pend[i];
            req_cmd[i*CW +: CW] = pcmd[i];
        end
        #1;
        g = pick();
        if (!do_rst) begin
            er = '0;
            if (mph == 0 && g >= 0) er[g] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(mph != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(mph == 2));
        end
        if (chk_zero) begin
            chk("rst_alsu_cmd", {16'd0, alsu_bypass_B, alsu_bypass_A, alsu_Opcode, alsu_red_op_B,
                                 alsu_red_op_A, alsu_Cin, alsu_B, alsu_A}, 32'd0);
            chk("rst_rsp_out", 32'(rsp_out), 32'd0);
            chk("rst_invalid_count", 32'(invalid_count), 32'd0);
        end
        if (do_rst) begin
            mph = 0; mptr = 0; mcnt = 0; q.delete();
        end else if (mph == 0 && g >= 0) begin
            r     = alsu_fn(pcmd[g]);
            e.id  = g;
            e.out = r[7:0];
            e.par = r[8];
            e.inv = r[9];
            if (e.inv && mcnt < 255) mcnt++;
            e.cnt = 8'(mcnt);
            e.cmd = pcmd[g];
            q.push_back(e);
            pend[g] = 1'b0;
            mptr    = (g + 1) % N;
            mph     = 1;
        end else if (mph == 1) mph = 2;
        else if (mph == 2 && rsp_ready) mph = 0;
    endtask

    // Monitor: every response cycle must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && rsp_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got id %0d out %0h expected no response", rsp_id, rsp_out);
                end else begin
                    e = q[0];
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_out", 32'(rsp_out), 32'(e.out));
                    chk("rsp_parity", 32'(rsp_odd_parity), 32'(e.par));
                    chk("rsp_invalid", 32'(rsp_invalid), 32'(e.inv));
                    chk("invalid_count", 32'(invalid_count), 32'(e.cnt));
                    chk("alsu_cmd", {16'd0, alsu_bypass_B, alsu_bypass_A, alsu_Opcode, alsu_red_op_B,
                                     alsu_red_op_A, alsu_Cin, alsu_B, alsu_A}, 32'(e.cmd));
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        responses++;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = 1'b0; req_valid = '0; req_cmd = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pcmd[i] = '0; end
        mptr = 0; mph = 0; mcnt = 0;
        repeat (2) cycle(0, 1'b1, 1'b0, 100, 1'b0);
        cycle(0, 1'b0, 1'b0, 100, 1'b1);

        // Single ADD from requester 2, then all four MULTs together.
        pend[2] = 1'b1; pcmd[2] = mk_cmd(3'b010, 4'd3, 4'd4, 1'b1);
        repeat (5) cycle(0, 1'b0, 1'b0, 100, 1'b0);
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pcmd[i] = mk_cmd(3'b011, 4'd15, 4'(i), 1'b0); end
        repeat (16) cycle(0, 1'b0, 1'b0, 100, 1'b0);
        // Divide by zero flags invalid.
        pend[1] = 1'b1; pcmd[1] = mk_cmd(3'b101, 4'd15, 4'd0, 1'b0);
        repeat (5) cycle(0, 1'b0, 1'b0, 100, 1'b0);

        repeat (1500) cycle(0, 1'b0, 1'b1, 65, 1'b0);
        repeat (1300) cycle(1, 1'b0, 1'b1, 70, 1'b0);
        cycle(0, 1'b0, 1'b0, 0, 1'b0);
        chk("invalid_saturated", 32'(invalid_count), 32'd255);

        // Reset while a response is pending, then 0110 must grant 1 first.
        guard = 0;
        while (mph != 2 && guard < 50) begin
            cycle(0, 1'b0, 1'b1, 0, 1'b0);
            guard++;
        end
        chk("reach_resp", 32'(mph), 32'd2);
        cycle(0, 1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        pend[1] = 1'b1; pcmd[1] = rand_cmd(0);
        pend[2] = 1'b1; pcmd[2] = rand_cmd(0);
        cycle(0, 1'b0, 1'b0, 100, 1'b1);
        repeat (300) cycle(0, 1'b0, 1'b1, 65, 1'b0);

        chk("responses_seen", 32'(responses > 400), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alsu_req_arbiter.md
# alsu_req_arbiter

Front-end controller that shares one combinational ALSU instance between `NUM_REQ` requesters. It arbitrates round-robin, latches the winning command into operand registers that drive the ALSU, and captures the ALSU result one cycle later. The result is returned through a valid/ready response channel tagged with the requester ID. The block sits between the requester ports and the ALSU; the ALSU itself is instantiated by the parent, not inside this block.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, ≥2.
- `WIDTH`, 4: ALSU operand width; the result is `2*WIDTH` bits.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, `NUM_REQ`: one bit per requester; held until accepted.
- `req_cmd`, in, `NUM_REQ*CMD_W`: flattened commands, `CMD_W = 2*WIDTH+8`. Field layout within slice i:
  - `A` = [W-1:0]
  - `B` = [2W-1:W]
  - `Cin` = [2W]
  - `red_op_A` = [2W+1]
  - `red_op_B` = [2W+2]
  - `Opcode` = [2W+5:2W+3]
  - `bypass_A` = [2W+6]
  - `bypass_B` = [2W+7]
- `req_ready`, out, `NUM_REQ`: one-hot or zero; the handshake completes on `valid & ready`.
- `alsu_A`, `alsu_B`, out, `WIDTH` each: registered operands to the ALSU.
- `alsu_Cin`, `alsu_red_op_A`, `alsu_red_op_B`, `alsu_bypass_A`, `alsu_bypass_B`, out, 1 each: registered controls.
- `alsu_Opcode`, out, 3: registered opcode.
- `alsu_out`, in, `2*WIDTH`: ALSU result, combinational from the `alsu_*` outputs.
- `alsu_odd_parity`, `alsu_invalid`, in, 1 each: ALSU flags.
- `rsp_valid`, out, 1: response available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_id`, out, `$clog2(NUM_REQ)`: index of the requester that issued the command.
- `rsp_out`, out, `2*WIDTH`: captured result.
- `rsp_odd_parity`, `rsp_invalid`, out, 1 each: captured flags.
- `invalid_count`, out, 8: saturating count of captured `alsu_invalid=1` results.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- State machine `IDLE → EXEC → RESP → IDLE`.
- **IDLE**
  - If any `req_valid` is set, the round-robin picker selects `g`.
  - `req_ready[g]=1` combinationally in this cycle.
  - On the clock edge: slice `g` is latched into the `alsu_*` registers, `g` is latched into the ID register, and the state moves to EXEC.
  - No valid requests: all `req_ready` are 0 and the state stays IDLE.
- **EXEC**
  - The `alsu_*` registers drive the ALSU and settle for one full cycle.
  - At the edge: `alsu_out`, `alsu_odd_parity` and `alsu_invalid` are captured into the `rsp_*` registers.
  - `invalid_count` increments if `alsu_invalid=1`; it holds at 255 once saturated.
  - The state moves to RESP.
- **RESP**
  - `rsp_valid=1`, and all `rsp_*` outputs are stable.
  - When `rsp_ready=1`, the state moves to IDLE. A new grant is possible only in the following cycle.
- **Round-robin**
  - Pointer `p` resets to 0.
  - The search runs from `p` upward and wraps modulo `NUM_REQ`.
  - After a grant to `g`, `p ← (g+1) mod NUM_REQ`. The pointer updates only on a grant.
- `req_ready` is always 0 outside IDLE. Requesters must not make `req_valid` depend on `req_ready`.
- The block never inspects opcodes. Invalid opcodes (110/111), divide-by-zero and reduction misuse pass through unchanged in the ALSU flags.
- The `alsu_*` registers hold their value after capture and change only on the next grant.

## Timing
- Grant edge = cycle 0. `rsp_valid` rises at cycle 2.
- Minimum occupancy is 3 cycles per command, so peak throughput is one result per 3 cycles.
- Backpressure: RESP holds for any number of `rsp_ready=0` cycles, with no change to outputs and no grants.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep `req_valid` asserted.
- Reset (`rst_n=0` at an edge), including mid-EXEC or mid-RESP:
  - Any pending response is discarded.
  - State ← IDLE, `p` ← 0.
  - All outputs go to 0: `req_ready`, `alsu_*`, `rsp_*`, `invalid_count`, `busy`.

## Structure
- Package `alsu_pkg` holds:
  - Opcode constants: AND=000, XOR=001, ADD=010, MULT=011, SUB_ABS=100, DIV=101.
  - `CMD_W` and the field offset functions/localparams.
  - The state enum `{IDLE, EXEC, RESP}`.
- Sub-module `rr_picker`: combinational inputs `valid` and `ptr`, outputs one-hot `grant` and `grant_idx`. It is reused by later shared-resource blocks.
- The top-level module contains the FSM, operand/result registers, pointer and counter.

## Test plan
All scenarios use `WIDTH=4`, `NUM_REQ=4`, with a real ALSU attached.
- **Single add:** requester 2 sends ADD, A=3, B=4, Cin=1, `rsp_ready=1` → `rsp_valid` at cycle 2 with `rsp_id=2`, `rsp_out=8'h08`, `rsp_invalid=0`; `busy` low again at cycle 3.
- **Simultaneous requests:** all four `req_valid` rise together with MULT A=15, B=i → grants in order 0,1,2,3; `rsp_out` values 0x00, 0x0F, 0x1E, 0x2D; each `req_ready` pulses for exactly one cycle.
- **Backpressure:** `rsp_ready=0` for 5 cycles during RESP → `rsp_*` stable, `req_ready` stays 0 despite pending `req_valid`; accepted on the 6th cycle.
- **Invalid-count saturation:** DIV A=15, B=0 → `rsp_invalid=1`, `invalid_count=1`. Repeat opcode 111 another 300 times → `invalid_count=255`, held.
- **Pointer after grant:** grant to 3 → next grant with `req_valid=4'b1001` goes to 0 (wrap).
- **Reset mid-operation:** `rst_n=0` during RESP → next cycle `rsp_valid=0`, `alsu_*=0`, `invalid_count=0`. After release, `req_valid=4'b0110` grants 1 first, since `p=0`.
